// File: rtl/smpc_pad_dev.sv
// Saturn peripheral-port device: TH/TR digital pad select, plus the TH/TR/TL
// 3-wire analog handshake (ID 0x16) when SMPC_PAD_3WIRE_EN is defined.
module smpc_pad_dev #(
  parameter int unsigned ACK_DLY = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic [6:0]  PI,
  output logic [6:0]  PO,
  input  logic [15:0] JOY,
  input  logic [7:0]  AX,
  input  logic [7:0]  AY,
  input  logic [7:0]  AR,
  input  logic [7:0]  AL,
  input  logic        MODE_ANALOG
);

  logic        th_q, tr_q, th_old_q, tr_old_q;
  logic [15:3] joy_q;
  logic        tl_q;
  logic [3:0]  nib_q;
  logic [3:0]  dig_nib_s;

  function automatic logic [3:0] sel_nib(input logic th, input logic tr, input logic [15:3] j);
    logic [3:0] r;
    case ({th, tr})
      2'b11:   r = {j[3], 3'b100};
      2'b01:   r = j[7:4];
      2'b10:   r = j[15:12];
      default: r = j[11:8];
    endcase
    return r;
  endfunction

  assign dig_nib_s = sel_nib(th_q, tr_q, joy_q);
  assign PO        = {2'b11, tl_q, nib_q};

  // Input stage: select lines and buttons, plus a second TH/TR stage for edges
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      th_q     <= 1'b1;
      tr_q     <= 1'b1;
      th_old_q <= 1'b1;
      tr_old_q <= 1'b1;
      joy_q    <= {13{1'b1}};
    end else if (CE) begin
      th_q     <= PI[6];
      tr_q     <= PI[5];
      th_old_q <= th_q;
      tr_old_q <= tr_q;
      joy_q    <= JOY[15:3];
    end
  end

`ifdef SMPC_PAD_3WIRE_EN
  typedef enum logic [1:0] {
    ST_DIG     = 2'd0,
    ST_HS_WAIT = 2'd1,
    ST_HS_DLY  = 2'd2,
    ST_HS_END  = 2'd3
  } state_t;

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [7:0]  cnt_q;
  logic [55:0] pkt_q;
  logic        th_fall_s, th_rise_s, tr_edge_s;
  logic        unused_s;

  // Nibble i of the packet, most significant nibble first
  function automatic logic [3:0] pkt_nib(input logic [55:0] p, input logic [3:0] i);
    logic [55:0] s;
    s = p << {i, 2'b00};
    return s[55:52];
  endfunction

  assign th_fall_s = th_old_q & ~th_q;
  assign th_rise_s = ~th_old_q & th_q;
  assign tr_edge_s = tr_old_q ^ tr_q;
  assign unused_s  = ^{PI[4:0], JOY[2:0]};

  // Protocol FSM with registered TL and data nibble
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_DIG;
      idx_q   <= 4'd0;
      cnt_q   <= 8'd0;
      pkt_q   <= 56'd0;
      tl_q    <= 1'b1;
      nib_q   <= 4'hC;
    end else if (CE) begin
      if (state_q != ST_DIG && th_rise_s) begin
        // TH rise aborts any handshake, even with an ack pending
        state_q <= ST_DIG;
        idx_q   <= 4'd0;
        cnt_q   <= 8'd0;
        tl_q    <= 1'b1;
        nib_q   <= dig_nib_s;
      end else begin
        case (state_q)
          ST_DIG: begin
            tl_q  <= 1'b1;
            nib_q <= dig_nib_s;
            if (MODE_ANALOG && th_fall_s) begin
              state_q <= ST_HS_WAIT;
              pkt_q   <= {8'h16, JOY[15:3], 3'b000, AX, AY, AR, AL};
              idx_q   <= 4'd0;
              cnt_q   <= 8'd0;
            end
          end
          ST_HS_WAIT, ST_HS_END: begin
            if (tr_edge_s) begin
              cnt_q   <= 8'(ACK_DLY);
              state_q <= ST_HS_DLY;
            end
          end
          ST_HS_DLY: begin
            // TR edges here are dropped; data and TL change on the same edge
            if (cnt_q > 8'd1) begin
              cnt_q <= cnt_q - 8'd1;
            end else begin
              cnt_q <= 8'd0;
              tl_q  <= ~tl_q;
              if (idx_q == 4'd14) begin
                nib_q   <= 4'h0;
                state_q <= ST_HS_END;
              end else begin
                nib_q   <= pkt_nib(pkt_q, idx_q);
                idx_q   <= idx_q + 4'd1;
                state_q <= (idx_q == 4'd13) ? ST_HS_END : ST_HS_WAIT;
              end
            end
          end
          default: state_q <= ST_DIG;
        endcase
      end
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{PI[4:0], JOY[2:0], AX, AY, AR, AL, MODE_ANALOG,
                      th_old_q, tr_old_q, 8'(ACK_DLY)};

  // Digital-only output register; TL is held high
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tl_q  <= 1'b1;
      nib_q <= 4'hC;
    end else if (CE) begin
      tl_q  <= 1'b1;
      nib_q <= dig_nib_s;
    end
  end
`endif

endmodule
